nios_dbg_ocimem_ctrl: RTL



---
 rtl/nios_dbg_pkg.sv | 20 ++
 rtl/nios_dbg_wait_timer.sv | 41 ++++
 rtl/nios_dbg_ocimem_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/nios_dbg_pkg.sv
// Shared types and constants for the Nios debug on-chip-memory controller.
package nios_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ocimem_state_e;

  localparam int JDO_W           = 38;
  localparam int JDO_RDFLAG      = 35;
  localparam int JDO_DATA_HI     = 34;
  localparam int JDO_DATA_LO     = 3;
  localparam int JDO_ADDR_LO     = 17;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int TIMER_W         = 16;

endpackage

// File: rtl/nios_dbg_wait_timer.sv
// Saturating stall counter; expired_o flags the stall cycle that reaches limit_i.
module nios_dbg_wait_timer
  import nios_dbg_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         expired_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The stall cycle that would bring the count up to the limit is the last one allowed.
  assign expired_o = en_i && (({1'b0, count_q} + (W + 1)'(1)) >= {1'b0, limit_i});
  assign count_o   = count_q;

endmodule

// File: rtl/nios_dbg_ocimem_ctrl.sv
// Debug-RAM access engine: turns ocimem take-action strobes into single Avalon-MM reads/writes.
module nios_dbg_ocimem_ctrl
  import nios_dbg_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  input  logic [31:0]       ram_readdata,
  input  logic              ram_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);

  ocimem_state_e     state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              ovr_q, ovr_d;
  logic              incr_q, incr_d;

  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_data;
  logic              jdo_rdflag;
  logic              strobe_any;
  logic              busy;
  logic              tmr_expired;
  logic [TIMER_W-1:0] tmr_count;
  logic              unused_bits;

  assign jdo_addr   = jdo[ADDR_W+16:JDO_ADDR_LO];
  assign jdo_data   = jdo[JDO_DATA_HI:JDO_DATA_LO];
  assign jdo_rdflag = jdo[JDO_RDFLAG];
  assign strobe_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign busy       = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign unused_bits = ^{jdo[JDO_W-1:JDO_RDFLAG+1], jdo[JDO_DATA_LO-1:0], tmr_count};

  nios_dbg_wait_timer #(
    .W (TIMER_W)
  ) u_wait_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (!busy),
    .en_i      (busy && ram_waitrequest),
    .limit_i   (LIMIT),
    .count_o   (tmr_count),
    .expired_o (tmr_expired)
  );

  // NOTE: every _d gets its held value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    ready_d = ready_q;
    error_d = error_q;
    ovr_d   = ovr_q;
    incr_d  = incr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (strobe_any) begin
          ready_d = 1'b0;
          error_d = 1'b0;
          ovr_d   = 1'b0;
        end
        if (take_action_ocimem_b) begin
          mon_d_d = jdo_data;
          wdata_d = jdo_data;
          write_d = 1'b1;
          state_d = ST_WRITE;
        end else if (take_action_ocimem_a) begin
          mon_a_d = jdo_addr;
          incr_d  = 1'b0;
          if (jdo_rdflag) begin
            read_d  = 1'b1;
            state_d = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end else if (take_no_action_ocimem_a) begin
          incr_d  = 1'b1;
          read_d  = 1'b1;
          state_d = ST_READ;
        end
      end

      ST_READ, ST_WRITE: begin
        if (strobe_any) ovr_d = 1'b1;
        if (!ram_waitrequest) begin
          if (state_q == ST_READ) begin
            mon_d_d = ram_readdata;
            if (incr_q) mon_a_d = mon_a_q + ADDR_W'(1);
          end else begin
            mon_a_d = mon_a_q + ADDR_W'(1);
          end
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          error_d = ovr_q | strobe_any;
          state_d = ST_DONE;
        end else if (tmr_expired) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Ready is normally raised on entry; this also covers the no-read address load.
        ready_d = 1'b1;
        if (strobe_any) error_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mon_a_q <= '0;
      mon_d_q <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
      ovr_q   <= 1'b0;
      incr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      ready_q <= ready_d;
      error_q <= error_d;
      ovr_q   <= ovr_d;
      incr_q  <= incr_d;
    end
  end

  assign ram_address   = mon_a_q;
  assign ram_read      = read_q;
  assign ram_write     = write_q;
  assign ram_writedata = wdata_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule
